// File: rtl/step_pkg.sv
// Shared types and constants for the step tick generator.
package step_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    localparam int                  SPEED_W     = 3;
    localparam logic [SPEED_W-1:0]  SPEED_MAX   = 3'd7;
    localparam logic [SPEED_W-1:0]  SPEED_RESET = 3'd4;

endpackage

// File: rtl/btn_debounce.sv
// Raw active-low button -> 2-flop sync, debounced level, one-cycle press pulse on accepted 1->0.
// Latency: press fires DEBOUNCE_CYCLES + 3 edges after a steady low first reaches the sync; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_n;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/step_tick_gen.sv
// Buttons + direction switch -> one-cycle step strobe at one of eight rates, with pause.
// Step period BASE_DIV << (7 - speed); button actions land DEBOUNCE_CYCLES + 4 edges after press; no backpressure.
module step_tick_gen
    import step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BASE_DIV        = 781250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_faster_n,
    input  logic               btn_slower_n,
    input  logic               btn_pause_n,
    input  logic               sw_dir,
    output logic               step,
    output logic               dir,
    output logic [SPEED_W-1:0] speed,
    output logic               paused
);

    localparam int PW = $clog2(BASE_DIV * 128);

    logic               faster_p, slower_p, pause_p;
    logic               lvl_faster, lvl_slower, lvl_pause;
    logic               unused_levels;
    logic               dsync1_q, dsync2_q, dir_q;
    logic [SPEED_W-1:0] speed_q, speed_d;
    state_t             state_q, state_d;
    logic [PW-1:0]      cnt_q, cnt_d;
    logic               step_q, step_d;
    logic [PW:0]        period;
    logic               term;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_faster (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_faster_n), .level(lvl_faster), .press(faster_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slower (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_slower_n), .level(lvl_slower), .press(slower_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_pause_n), .level(lvl_pause), .press(pause_p)
    );

    assign unused_levels = &{1'b0, lvl_faster, lvl_slower, lvl_pause};

    assign period = (PW+1)'(BASE_DIV) << (SPEED_MAX - speed_q);
    assign term   = ({1'b0, cnt_q} == period - (PW+1)'(1));

    always_comb begin
        speed_d = speed_q;
        if (faster_p && !slower_p && speed_q != SPEED_MAX) begin
            speed_d = speed_q + SPEED_W'(1);
        end else if (slower_p && !faster_p && speed_q != '0) begin
            speed_d = speed_q - SPEED_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (pause_p) begin
                    // A pause that swallows a terminal count restarts the period on resume.
                    state_d = PAUSE;
                    if (term) begin
                        cnt_d = '0;
                    end
                end else if (term) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            PAUSE: begin
                if (pause_p) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (speed_d != speed_q) begin
            cnt_d  = '0;
            step_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsync1_q <= 1'b0;
            dsync2_q <= 1'b0;
            dir_q    <= 1'b0;
            speed_q  <= SPEED_RESET;
            state_q  <= RUN;
            cnt_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            dsync1_q <= sw_dir;
            dsync2_q <= dsync1_q;
            dir_q    <= dsync2_q;
            speed_q  <= speed_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
        end
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign speed  = speed_q;
    assign paused = (state_q == PAUSE);

endmodule

// File: tb/tb_step_tick_gen.sv
// Bench for step_tick_gen: per-cycle comparison against a rule-level model, a press table, and timing sequences.
module tb_step_tick_gen;

    localparam int D  = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_f = 1'b1, btn_s = 1'b1, btn_p = 1'b1, sw = 1'b0;
    logic       step_o, dir_o, paused_o;
    logic [2:0] speed_o;

    always #5 clk = ~clk;

    step_tick_gen #(.DEBOUNCE_CYCLES(D), .BASE_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_faster_n(btn_f), .btn_slower_n(btn_s), .btn_pause_n(btn_p),
        .sw_dir(sw),
        .step(step_o), .dir(dir_o), .speed(speed_o), .paused(paused_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: raw sample history per button, accepted levels, press pipeline,
    // and elapsed running cycles since the last step / restart.
    bit [D+1:0] hist[3];
    bit         lvl[3];
    bit         accepted[3];
    bit         pressed[3];
    int         m_speed;
    bit         m_paused;
    int         m_el;
    bit         m_step;
    bit [2:0]   swh;
    bit         m_dir;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            hist[b]     = '1;
            lvl[b]      = 1'b1;
            accepted[b] = 1'b0;
            pressed[b]  = 1'b0;
        end
        m_speed  = 4;
        m_paused = 1'b0;
        m_el     = 0;
        m_step   = 1'b0;
        swh      = '0;
        m_dir    = 1'b0;
    endtask

    task automatic model_edge();
        bit r[3];
        bit act[3];
        bit flip;
        int period;
        int nsp;
        r[0] = btn_f; r[1] = btn_s; r[2] = btn_p;
        for (int b = 0; b < 3; b++) begin
            act[b]      = pressed[b];
            pressed[b]  = accepted[b];
            accepted[b] = 1'b0;
            hist[b]     = {hist[b][D:0], r[b]};
            // level flips once the last D synchronized samples all disagree with it
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++) if (hist[b][k] == lvl[b]) flip = 1'b0;
            if (flip) begin
                lvl[b]      = ~lvl[b];
                accepted[b] = (lvl[b] == 1'b0);
            end
        end
        period = BD << (7 - m_speed);
        nsp = m_speed;
        if (act[0] && !act[1] && m_speed < 7) nsp = m_speed + 1;
        else if (act[1] && !act[0] && m_speed > 0) nsp = m_speed - 1;
        m_step = 1'b0;
        if (m_paused) begin
            if (act[2]) m_paused = 1'b0;
        end else if (act[2]) begin
            m_paused = 1'b1;
            if (m_el == period - 1) m_el = 0;
        end else begin
            m_el = m_el + 1;
            if (m_el == period) begin
                m_step = 1'b1;
                m_el   = 0;
            end
        end
        if (nsp != m_speed) begin
            m_el    = 0;
            m_step  = 1'b0;
            m_speed = nsp;
        end
        swh   = {swh[1:0], sw};
        m_dir = swh[2];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (rst_n) begin
            chk("step",   int'(step_o),   int'(m_step));
            chk("dir",    int'(dir_o),    int'(m_dir));
            chk("speed",  int'(speed_o),  m_speed);
            chk("paused", int'(paused_o), int'(m_paused));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        btn_f = 1'b1; btn_s = 1'b1; btn_p = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic press(input bit f, input bit s, input bit p, input int hold, input int idle);
        btn_f = ~f; btn_s = ~s; btn_p = ~p;
        repeat (hold) cycle();
        btn_f = 1'b1; btn_s = 1'b1; btn_p = 1'b1;
        repeat (idle) cycle();
    endtask

    task automatic wait_step(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cycle();
            if (step_o) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        bit f;
        bit s;
        bit p;
        int exp_speed;
        int exp_paused;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n, chg, s1, s2, pe, r, sr, nst;
        tbl[0]  = '{1, 0, 0, 5, 0};
        tbl[1]  = '{1, 0, 0, 6, 0};
        tbl[2]  = '{1, 0, 0, 7, 0};
        tbl[3]  = '{1, 0, 0, 7, 0};
        tbl[4]  = '{0, 1, 0, 6, 0};
        tbl[5]  = '{0, 1, 0, 5, 0};
        tbl[6]  = '{0, 1, 0, 4, 0};
        tbl[7]  = '{0, 1, 0, 3, 0};
        tbl[8]  = '{1, 1, 0, 3, 0};
        tbl[9]  = '{0, 0, 1, 3, 1};
        tbl[10] = '{0, 1, 0, 2, 1};
        tbl[11] = '{1, 1, 0, 2, 1};
        tbl[12] = '{0, 0, 1, 2, 0};
        tbl[13] = '{0, 1, 0, 1, 0};
        tbl[14] = '{0, 1, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 0, 0};

        model_reset();
        @(negedge clk);
        do_reset();

        // reset state and free-running cadence at speed 4
        wait_step(40, n);
        chk("first_step_edge", n, 16);
        wait_step(40, n);
        chk("step_spacing_16", n, 16);

        // bounce on slower: 3 low, 1 high, 3 low never reaches acceptance
        btn_s = 1'b0; repeat (3) cycle();
        btn_s = 1'b1; cycle();
        btn_s = 1'b0; repeat (3) cycle();
        btn_s = 1'b1; repeat (20) cycle();
        chk("bounce_speed", int'(speed_o), 4);

        // faster press: speed change on edge 8, then 8-cycle cadence
        chg = 0; s1 = 0; s2 = 0;
        btn_f = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 11) btn_f = 1'b1;
            cycle();
            if (chg == 0 && speed_o == 3'd5) chg = i;
            else if (chg != 0 && step_o) begin
                if (s1 == 0) s1 = i;
                else if (s2 == 0) s2 = i;
            end
        end
        chk("faster_edge", chg, 8);
        chk("faster_first_step", s1 - chg, 8);
        chk("faster_spacing", s2 - s1, 8);

        // press table from reset, including saturation and simultaneous presses
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press(tbl[i].f, tbl[i].s, tbl[i].p, 10, 10);
            chk($sformatf("vec%0d_speed", i), int'(speed_o), tbl[i].exp_speed);
            chk($sformatf("vec%0d_paused", i), int'(paused_o), tbl[i].exp_paused);
        end

        // pause landing with the prescaler at 5, resume 11 cycles before the next step
        do_reset();
        wait_step(40, n);
        repeat (14) cycle();
        pe = 0;
        btn_p = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (j == 11) btn_p = 1'b1;
            cycle();
            if (pe == 0 && paused_o) pe = j;
        end
        chk("pause_edge", pe, 8);
        nst = 0;
        repeat (30) begin
            cycle();
            if (step_o) nst++;
        end
        chk("paused_steps", nst, 0);
        chk("paused_flag", int'(paused_o), 1);
        r = 0; sr = 0;
        btn_p = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            if (j == 11) btn_p = 1'b1;
            cycle();
            if (r == 0 && !paused_o) r = j;
            else if (r != 0 && sr == 0 && step_o) sr = j;
        end
        chk("resume_edge", r, 8);
        chk("resume_to_step", sr - r, 11);

        // asynchronous reset while paused at speed 6 with dir high
        do_reset();
        sw = 1'b1;
        press(1, 0, 0, 10, 10);
        press(1, 0, 0, 10, 10);
        press(0, 0, 1, 10, 10);
        chk("pre_reset_speed", int'(speed_o), 6);
        chk("pre_reset_paused", int'(paused_o), 1);
        chk("pre_reset_dir", int'(dir_o), 1);
        repeat (3) cycle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_step", int'(step_o), 0);
        chk("arst_dir", int'(dir_o), 0);
        chk("arst_speed", int'(speed_o), 4);
        chk("arst_paused", int'(paused_o), 0);
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;
        wait_step(40, n);
        chk("post_reset_first_step", n, 16);
        wait_step(40, n);
        chk("post_reset_spacing", n, 16);

        // random buttons and switch against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (btn_f) btn_f = ($urandom_range(0, 11) != 0); else btn_f = ($urandom_range(0, 7) == 0);
            if (btn_s) btn_s = ($urandom_range(0, 11) != 0); else btn_s = ($urandom_range(0, 7) == 0);
            if (btn_p) btn_p = ($urandom_range(0, 15) != 0); else btn_p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) sw = ~sw;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
